// File: rtl/lsu_pkg.sv
// lsu_pkg -- shared definitions for the load/store data-memory controller.
//   Access-size encodings, controller state codes, bus widths and the
//   alignment rule used at request acceptance.
package lsu_pkg;

    localparam int LSU_ADDR_W = 12;
    localparam int LSU_DATA_W = 64;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [1:0] SZ_DWORD = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RD   = 2'd1;
    localparam state_t ST_WR   = 2'd2;
    localparam state_t ST_RESP = 2'd3;

    // An access is misaligned when its byte offset inside the doubleword
    // is not a multiple of the access size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] lane);
        logic mis;
        case (size)
            SZ_HALF:  mis = lane[0];
            SZ_WORD:  mis = |lane[1:0];
            SZ_DWORD: mis = |lane;
            default:  mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align -- combinational byte-lane handling for the LSU.
//   size      : access size encoding
//   sign_ext  : sign-extend the extracted load value
//   lane      : byte offset of the access inside the doubleword
//   wdata     : store data, right-aligned
//   rdata     : doubleword read from data memory
//   merged    : rdata with the addressed lanes replaced by wdata's low bytes
//   extracted : addressed lanes of rdata, right-aligned and extended
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]            size,
    input  logic                  sign_ext,
    input  logic [2:0]            lane,
    input  logic [LSU_DATA_W-1:0] wdata,
    input  logic [LSU_DATA_W-1:0] rdata,
    output logic [LSU_DATA_W-1:0] merged,
    output logic [LSU_DATA_W-1:0] extracted
);

    logic [5:0]            shamt;
    logic [LSU_DATA_W-1:0] size_mask;
    logic [LSU_DATA_W-1:0] lane_mask;
    logic [LSU_DATA_W-1:0] shifted;

    assign shamt = {lane, 3'b000};

    always_comb begin
        size_mask = '1;
        case (size)
            SZ_BYTE: size_mask = 64'h0000_0000_0000_00FF;
            SZ_HALF: size_mask = 64'h0000_0000_0000_FFFF;
            SZ_WORD: size_mask = 64'h0000_0000_FFFF_FFFF;
            default: size_mask = '1;
        endcase
    end

    // Only aligned accesses reach here, so the shifted mask never wraps.
    assign lane_mask = size_mask << shamt;
    assign merged    = (rdata & ~lane_mask) | ((wdata << shamt) & lane_mask);
    assign shifted   = rdata >> shamt;

    always_comb begin
        extracted = shifted;
        case (size)
            SZ_BYTE: extracted = {{56{sign_ext & shifted[7]}},  shifted[7:0]};
            SZ_HALF: extracted = {{48{sign_ext & shifted[15]}}, shifted[15:0]};
            SZ_WORD: extracted = {{32{sign_ext & shifted[31]}}, shifted[31:0]};
            default: extracted = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_dm_ctrl.sv
// lsu_dm_ctrl -- single-outstanding load/store controller for a
// doubleword-wide, combinational-read data memory.
//   clk, rst                 : clock, async active-high reset
//   req_valid / req_ready    : request handshake (ready only in IDLE)
//   req_wr, req_size, req_signed, req_addr, req_wdata : request fields
//   resp_valid, resp_data, resp_err : one-cycle completion
//   direccion, dataWrite, memWr, dataRead : data-memory port
//
// state | meaning
// IDLE  | ready for a request; memory address held at 0
// RD    | sample memory: extract load result or build store merge
// WR    | memWr pulse with the merged doubleword
// RESP  | resp_valid pulse, then back to IDLE
module lsu_dm_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = LSU_ADDR_W,
    parameter int DATA_W = LSU_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic [ADDR_W-1:0] direccion,
    output logic [DATA_W-1:0] dataWrite,
    output logic              memWr,
    input  logic [DATA_W-1:0] dataRead
);

    state_t            state;
    logic              cap_wr;
    logic [1:0]        cap_size;
    logic              cap_signed;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] extracted;
    logic              req_mis;

    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign memWr      = (state == ST_WR);
    assign direccion  = (state == ST_IDLE) ? '0 : {3'b000, cap_addr[ADDR_W-1:3]};
    assign req_mis    = is_misaligned(req_size, req_addr[2:0]);

    lsu_align u_align (
        .size      (cap_size),
        .sign_ext  (cap_signed),
        .lane      (cap_addr[2:0]),
        .wdata     (cap_wdata),
        .rdata     (dataRead),
        .merged    (merged),
        .extracted (extracted)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cap_wr     <= 1'b0;
            cap_size   <= '0;
            cap_signed <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            dataWrite  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        cap_wr     <= req_wr;
                        cap_size   <= req_size;
                        cap_signed <= req_signed;
                        cap_addr   <= req_addr;
                        cap_wdata  <= req_wdata;
                        resp_data  <= '0;
                        resp_err   <= req_mis;
                        if (req_mis) begin
                            state <= ST_RESP;
                        end else if (req_wr && req_size == SZ_DWORD) begin
                            // Full-width store needs no read-modify-write.
                            dataWrite <= req_wdata;
                            state     <= ST_WR;
                        end else begin
                            state <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (cap_wr) begin
                        dataWrite <= merged;
                        state     <= ST_WR;
                    end else begin
                        resp_data <= extracted;
                        state     <= ST_RESP;
                    end
                end
                ST_WR: begin
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    resp_data <= '0;
                    resp_err  <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_dm_ctrl.sv
// tb_lsu_dm_ctrl -- directed and randomized checks of lsu_dm_ctrl against a
// byte-level reference model and a doubleword memory.
module tb_lsu_dm_ctrl;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [11:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic        resp_err;
    logic [11:0] direccion;
    logic [63:0] dataWrite;
    logic        memWr;
    logic [63:0] dataRead;

    logic        mem_init;
    logic [63:0] mem     [0:4095];
    logic [63:0] ref_mem [0:4095];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_dm_ctrl #(.ADDR_W(12), .DATA_W(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .direccion  (direccion),
        .dataWrite  (dataWrite),
        .memWr      (memWr),
        .dataRead   (dataRead)
    );

    function automatic logic [63:0] init_val(input int i);
        logic [31:0] a;
        logic [31:0] b;
        a = i * 32'h9E37_79B9 + 32'h1234_5678;
        b = (i + 7) * 32'h85EB_CA6B;
        return {a, b};
    endfunction

    assign dataRead = mem[direccion];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++) mem[i] <= init_val(i);
        end else if (memWr) begin
            mem[direccion] <= dataWrite;
        end
    end

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [1:0] s);
        return 1 << s;
    endfunction

    function automatic logic model_mis(input logic [1:0] s, input logic [11:0] a);
        return (int'(a) % nbytes(s)) != 0;
    endfunction

    function automatic logic [63:0] model_merge(input logic [63:0] old, input logic [63:0] wd,
                                                input logic [11:0] a, input logic [1:0] s);
        logic [63:0] r;
        int lane;
        r = old;
        lane = int'(a[2:0]);
        for (int b = 0; b < nbytes(s); b++) r[(lane + b) * 8 +: 8] = wd[b * 8 +: 8];
        return r;
    endfunction

    function automatic logic [63:0] model_load(input logic [63:0] old, input logic [11:0] a,
                                               input logic [1:0] s, input logic sg);
        logic [63:0] v;
        int lane;
        int n;
        v = '0;
        lane = int'(a[2:0]);
        n = nbytes(s);
        for (int b = 0; b < n; b++) v[b * 8 +: 8] = old[(lane + b) * 8 +: 8];
        if (sg && n < 8 && v[n * 8 - 1]) begin
            for (int k = n * 8; k < 64; k++) v[k] = 1'b1;
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete transaction, checked cycle by cycle against the model.
    task automatic run_req(input logic wr, input logic [1:0] size, input logic sgn,
                           input logic [11:0] addr, input logic [63:0] wdata,
                           output logic [63:0] got);
        logic [63:0] old;
        logic [63:0] exp_mem;
        logic [63:0] exp_data;
        logic        mis;
        int          exp_lat;
        int          lat;
        int          writes;
        int          idx;
        idx  = int'(addr[11:3]);
        old  = ref_mem[idx];
        mis  = model_mis(size, addr);
        exp_mem  = old;
        exp_data = '0;
        if (mis) begin
            exp_lat = 1;
        end else if (!wr) begin
            exp_lat  = 2;
            exp_data = model_load(old, addr, size, sgn);
        end else begin
            exp_lat = (size == SZ_DWORD) ? 2 : 3;
            exp_mem = model_merge(old, wdata, addr, size);
        end

        @(negedge clk);
        req_wr = wr; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        chk("ready_idle", 64'(req_ready), 64'd1);
        @(posedge clk);
        lat = 0; writes = 0; got = '0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (memWr) begin
                writes++;
                chk("wr_cycle", 64'(n), 64'(exp_lat - 1));
                chk("wr_addr", 64'(direccion), 64'(idx));
                chk("wr_data", dataWrite, exp_mem);
            end
            if (resp_valid) begin
                lat = n;
                got = resp_data;
                chk("resp_data", resp_data, exp_data);
                chk("resp_err", 64'(resp_err), 64'(mis));
                chk("resp_addr", 64'(direccion), 64'(idx));
                break;
            end
        end
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("write_count", 64'(writes), (wr && !mis) ? 64'd1 : 64'd0);
        if (wr && !mis) ref_mem[idx] = exp_mem;
        chk("mem_contents", mem[idx], ref_mem[idx]);
    endtask

    initial begin
        logic [63:0] got;
        logic [63:0] hold_exp;
        int acc_cnt;
        int resp_cnt;
        int last_acc;

        rst = 1'b1; mem_init = 1'b1;
        req_valid = 1'b0; req_wr = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_err",   64'(resp_err),   64'd0);
        chk("rst_memwr",      64'(memWr),      64'd0);
        chk("rst_resp_data",  resp_data,       64'd0);
        chk("rst_datawrite",  dataWrite,       64'd0);
        chk("rst_direccion",  64'(direccion),  64'd0);
        mem_init = 1'b0;
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 64'(req_ready), 64'd1);

        // Doubleword store, then byte store merge.
        run_req(1'b1, SZ_DWORD, 1'b0, 12'h050, 64'h1122_3344_5566_7788, got);
        chk("dword_store_mem", mem[10], 64'h1122_3344_5566_7788);
        run_req(1'b1, SZ_BYTE, 1'b0, 12'h053, 64'h0000_0000_0000_00AB, got);
        chk("byte_store_mem", mem[10], 64'h1122_3344_AB66_7788);

        // Half loads, signed and unsigned.
        run_req(1'b1, SZ_DWORD, 1'b0, 12'h050, 64'h8001_0000_0000_0000, got);
        run_req(1'b0, SZ_HALF, 1'b1, 12'h056, 64'h0, got);
        chk("half_load_signed", got, 64'hFFFF_FFFF_FFFF_8001);
        run_req(1'b0, SZ_HALF, 1'b0, 12'h056, 64'h0, got);
        chk("half_load_unsigned", got, 64'h0000_0000_0000_8001);

        // Misaligned word store.
        run_req(1'b1, SZ_WORD, 1'b0, 12'h052, 64'hDEAD_BEEF_CAFE_F00D, got);
        chk("mis_store_data", got, 64'h0);
        chk("mis_store_mem", mem[10], 64'h8001_0000_0000_0000);

        // Reset while a partial store sits in RD.
        @(negedge clk);
        req_wr = 1'b1; req_size = SZ_BYTE; req_signed = 1'b0; req_addr = 12'h051;
        req_wdata = 64'hCC; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_rd_memwr", 64'(memWr), 64'd0);
        rst = 1'b1;
        #1;
        chk("abort_async_memwr", 64'(memWr), 64'd0);
        chk("abort_async_direccion", 64'(direccion), 64'd0);
        chk("abort_async_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        chk("abort_hold_memwr", 64'(memWr), 64'd0);
        rst = 1'b0;
        #1;
        chk("abort_ready_after", 64'(req_ready), 64'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("abort_no_write", 64'(memWr), 64'd0);
        end
        chk("abort_mem_unchanged", mem[10], ref_mem[10]);

        // req_valid held high across loads: one acceptance per IDLE visit.
        hold_exp = model_load(ref_mem[11], 12'h05C, SZ_WORD, 1'b0);
        req_wr = 1'b0; req_size = SZ_WORD; req_signed = 1'b0; req_addr = 12'h05C;
        req_wdata = '0; req_valid = 1'b1;
        acc_cnt = 0; resp_cnt = 0; last_acc = 0;
        for (int c = 0; c < 12; c++) begin
            if (req_ready) begin
                acc_cnt++;
                if (acc_cnt > 1) chk("hold_spacing", 64'(c - last_acc), 64'd3);
                last_acc = c;
            end
            if (resp_valid) begin
                resp_cnt++;
                chk("hold_resp_data", resp_data, hold_exp);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("hold_accept_count", 64'(acc_cnt), 64'd4);
        chk("hold_resp_count", 64'(resp_cnt), 64'd4);

        // Randomized traffic over a small window so loads hit earlier stores.
        for (int t = 0; t < 60; t++) begin
            run_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    12'(12'h040 + $urandom_range(0, 63)), {$urandom, $urandom}, got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
